// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline stage register with valid/ready handshake, 2-entry skid buffer, flush and bubble counter
module pipe_stage_reg #(
    parameter int               WIDTH      = 64,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] KEEP_MASK  = {WIDTH{1'b0}},
    parameter int               CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    logic             in_fire;
    logic             out_fire;
    logic [WIDTH-1:0] bubble_merge;

    assign in_ready   = en & ~flush & ~rst & (state_q != ST_FULL);
    assign out_valid  = (state_q != ST_EMPTY);
    assign out_data   = main_q;
    assign bubble_cnt = bubble_cnt_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready & en & ~flush;

    // Kept bits preserve the last payload (e.g. pc for debug); the rest become the nop pattern.
    assign bubble_merge = (main_q & KEEP_MASK) | (BUBBLE_VAL & ~KEEP_MASK);

    always_comb begin
        state_d      = state_q;
        main_d       = main_q;
        skid_d       = skid_q;
        bubble_cnt_d = bubble_cnt_q;

        if (en && out_ready && !out_valid && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end

        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = bubble_merge;
            skid_d  = BUBBLE_VAL;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_data;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        skid_d  = in_data;
                        state_d = ST_FULL;
                    end else if (out_fire) begin
                        main_d  = bubble_merge;
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // Skid entry is younger, so it only moves up once main has left.
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = BUBBLE_VAL;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            main_q       <= BUBBLE_VAL;
            skid_q       <= BUBBLE_VAL;
            bubble_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - randomized and directed bench for pipe_stage_reg against a queue model
module tb_pipe_stage_reg;

    localparam int          WIDTH = 64;
    localparam int          CNT_W = 2;
    localparam logic [63:0] BUBBLE = 64'h0000_0000_0000_0013;
    localparam logic [63:0] KEEP   = 64'hFFFF_FFFF_0000_0000;

    logic             clk = 1'b0;
    logic             rst, en, flush, in_valid, out_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_ready, out_valid;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] bubble_cnt;

    pipe_stage_reg #(
        .WIDTH(WIDTH), .BUBBLE_VAL(BUBBLE), .KEEP_MASK(KEEP), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference: FIFO of held instructions (oldest first) and the value shown when empty.
    logic [63:0] m_q[$];
    logic [63:0] m_disp;
    int          m_cnt;

    function automatic logic [63:0] merge(input logic [63:0] v);
        return (v & KEEP) | (BUBBLE & ~KEEP);
    endfunction

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit ofire, ifire;
        logic [63:0] popped;
        if (rst) begin
            m_q.delete();
            m_disp = BUBBLE;
            m_cnt  = 0;
        end else begin
            if (en && out_ready && m_q.size() == 0 && m_cnt < (1 << CNT_W) - 1) m_cnt++;
            if (flush) begin
                m_disp = merge(m_q.size() != 0 ? m_q[0] : m_disp);
                m_q.delete();
            end else if (en) begin
                ofire = out_ready && m_q.size() > 0;
                ifire = in_valid && m_q.size() < 2;
                if (ofire) begin
                    popped = m_q.pop_front();
                    if (m_q.size() == 0 && !ifire) m_disp = merge(popped);
                end
                if (ifire) m_q.push_back(in_data);
            end
        end
    endtask

    task automatic cyc(input bit r, input bit e, input bit f, input bit iv,
                       input logic [63:0] d, input bit ordy);
        bit exp_rdy;
        @(negedge clk);
        rst = r; en = e; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
        #1;
        exp_rdy = e && !f && !r && m_q.size() < 2;
        check_val("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
        @(posedge clk);
        model_step();
        #1;
        check_val("out_valid", {63'd0, out_valid}, {63'd0, m_q.size() != 0});
        check_val("out_data", out_data, m_q.size() != 0 ? m_q[0] : m_disp);
        check_val("bubble_cnt", {62'd0, bubble_cnt}, 64'(m_cnt));
    endtask

    initial begin
        m_disp = BUBBLE;
        m_cnt  = 0;
        rst = 1'b1; en = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset then stream 1,2,3
        cyc(1, 1, 0, 0, 0, 0);
        check_val("rst_data", out_data, BUBBLE);
        cyc(0, 1, 0, 1, 64'd1, 1);
        check_val("stream1", out_data, 64'd1);
        cyc(0, 1, 0, 1, 64'd2, 1);
        check_val("stream2", out_data, 64'd2);
        cyc(0, 1, 0, 1, 64'd3, 1);
        check_val("stream3", out_data, 64'd3);
        cyc(0, 1, 0, 0, 0, 1);

        // Back-pressure: A held, B in skid, then both drain in order
        cyc(0, 1, 0, 1, 64'hA, 0);
        cyc(0, 1, 0, 1, 64'hB, 0);
        check_val("bp_full_rdy", {63'd0, in_ready}, 64'd0);
        check_val("bp_hold", out_data, 64'hA);
        cyc(0, 1, 0, 1, 64'hC, 1);
        check_val("bp_second", out_data, 64'hB);
        cyc(0, 1, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 1);

        // Flush in FULL with simultaneous in_valid
        cyc(0, 1, 0, 1, 64'h1234_5678_9ABC_DEF0, 0);
        cyc(0, 1, 0, 1, 64'h5555_5555_5555_5555, 0);
        cyc(0, 1, 1, 1, 64'h7777_7777_7777_7777, 1);
        check_val("flush_valid", {63'd0, out_valid}, 64'd0);
        check_val("flush_data", out_data, 64'h1234_5678_0000_0013);
        cyc(0, 1, 0, 0, 0, 0);

        // Stall with traffic offered on both sides
        cyc(0, 1, 0, 1, 64'h21, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 64'h22, 1);
        check_val("stall_data", out_data, 64'h21);
        cyc(0, 1, 0, 1, 64'h22, 1);
        check_val("stall_resume", out_data, 64'h22);

        // Bubble counter saturation
        cyc(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, 1);
        check_val("cnt_sat", {62'd0, bubble_cnt}, 64'd3);

        // Reset with two entries held
        cyc(0, 1, 0, 1, 64'h31, 0);
        cyc(0, 1, 0, 1, 64'h32, 0);
        cyc(1, 1, 0, 1, 64'h33, 1);
        check_val("rst_full_cnt", {62'd0, bubble_cnt}, 64'd0);
        check_val("rst_full_data", out_data, BUBBLE);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 80,
                $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 60,
                {$urandom, $urandom}, $urandom_range(0, 99) < 60);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
